// File: rtl/midi_voice_allocator_pkg.sv
// Shared definitions for the MIDI voice allocator.
// Contents: status-nibble constants, the sustain controller number, the parser
// state type, the voice-age ceiling and the note-to-phase-increment function
// that the frequency ROM evaluates at elaboration time.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHPRESS    = 4'hD;
    localparam logic [6:0] CC_SUSTAIN = 7'h40;

    localparam int unsigned AGE_MAX = 255;

    typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2, StSkip} parse_state_e;

    localparam real Semitone = 1.0594630943592953;

    // round(440 * 2^((n-69)/12) * 2^w / fs), saturated to 2^w-1.
    // Frequency is walked one semitone at a time from A4 so no math library is needed.
    function automatic longint unsigned note_to_inc(int unsigned n, int unsigned w,
                                                    int unsigned fs);
        real    f;
        real    scale;
        real    inc;
        longint r;
        f = 440.0;
        for (int unsigned i = n; i < 69; i++) f = f / Semitone;
        for (int unsigned i = 69; i < n; i++) f = f * Semitone;
        scale = 1.0;
        for (int unsigned i = 0; i < w; i++) scale = scale * 2.0;
        inc = f * scale / real'(fs);
        if (inc + 0.5 >= scale) begin
            r = longint'(scale - 1.0);
        end else begin
            r = longint'($floor(inc + 0.5));
        end
        return r;
    endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Raw MIDI byte stream: one byte per cycle in which iMidiRe is high.
//   iMidiRd : MIDI byte
//   iMidiRe : byte strobe
// master drives the stream, slave (the allocator) consumes it.
interface midi_voice_allocator_if;
    logic [7:0] iMidiRd;
    logic       iMidiRe;

    modport master (output iMidiRd, output iMidiRe);
    modport slave  (input iMidiRd, input iMidiRe);
endinterface

// File: rtl/midi_voice_allocator_freq_rom.sv
// Note-number to phase-increment ROM, 128 x pAudioBitDepth, registered output,
// one read port per voice. A port only loads when its enable is high, so an
// idle voice keeps the increment of the note it last played (0 after reset).
//   iCLK, inRST : clock, asynchronous active-low reset
//   rd_en       : per-port load enable
//   rd_addr     : per-port note number
//   rd_data     : per-port registered phase increment
module midi_note_freq_rom
    import midi_pkg::*;
#(
    parameter int unsigned pChannel       = 4,
    parameter int unsigned pAudioBitDepth = 16,
    parameter int unsigned pSampleRate    = 48000
) (
    input  logic                                     iCLK,
    input  logic                                     inRST,
    input  logic [pChannel-1:0]                      rd_en,
    input  logic [pChannel-1:0][6:0]                 rd_addr,
    output logic [pChannel-1:0][pAudioBitDepth-1:0]  rd_data
);

    logic [pAudioBitDepth-1:0] rom [128];

    for (genvar n = 0; n < 128; n++) begin : g_tbl
        localparam logic [pAudioBitDepth-1:0] Val =
            pAudioBitDepth'(note_to_inc(n, pAudioBitDepth, pSampleRate));
        assign rom[n] = Val;
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            rd_data <= '0;
        end else begin
            for (int v = 0; v < int'(pChannel); v++) begin
                if (rd_en[v]) rd_data[v] <= rom[rd_addr[v]];
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice allocator.
// Parses a raw MIDI byte stream (running status, realtime, system messages),
// filters on pMidiCh (16 = omni) and spreads Note On/Off over pChannel voices:
// retrigger same note, else lowest free voice, else steal the oldest.
// Optional feature: define MIDI_SUSTAIN_EN to decode CC 0x40 as a sustain pedal.
// Ports:
//   iCLK, inRST  : clock, asynchronous active-low reset
//   midi         : MIDI byte stream (slave)
//   oAudioFreq   : per-voice phase increment, voice v at [v*W +: W]
//   oAudioPlay   : per-voice sounding flag
//   oNoteNumber  : per-voice note, oVelocity : per-voice velocity
//   oNoteOn      : per-voice pulse on (re)allocation
//   oVoiceSteal  : pulse when an allocation stole a sounding voice
//   oParseErr    : pulse on a data byte with no running status
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned pChannel       = 4,
    parameter int unsigned pAudioBitDepth = 16,
    parameter int unsigned pSampleRate    = 48000,
    parameter int unsigned pMidiCh        = 16
) (
    input  logic                                iCLK,
    input  logic                                inRST,
    midi_voice_allocator_if.slave               midi,
    output logic [pChannel*pAudioBitDepth-1:0]  oAudioFreq,
    output logic [pChannel-1:0]                 oAudioPlay,
    output logic [pChannel*7-1:0]               oNoteNumber,
    output logic [pChannel*7-1:0]               oVelocity,
    output logic [pChannel-1:0]                 oNoteOn,
    output logic                                oVoiceSteal,
    output logic                                oParseErr
);

    localparam int unsigned IdxW = (pChannel > 1) ? $clog2(pChannel) : 1;

    // ---------------- parser ----------------
    parse_state_e state_q;
    logic [7:0]   status_q;
    logic [6:0]   data1_q;
    logic         msg_valid_q;
    logic [3:0]   msg_type_q;
    logic [6:0]   msg_d1_q, msg_d2_q;
    logic         parse_err_q;

    logic [7:0] byte_in;
    logic       ch_ok, one_byte, msg_keep;

    assign byte_in  = midi.iMidiRd;
    assign ch_ok    = (pMidiCh >= 16) || (status_q[3:0] == 4'(pMidiCh));
    assign one_byte = (status_q[7:4] == PROG) || (status_q[7:4] == CHPRESS);

    // Only messages that change voice state are forwarded to the execute stage.
    always_comb begin
        msg_keep = ch_ok && ((status_q[7:4] == NOTE_OFF) || (status_q[7:4] == NOTE_ON));
`ifdef MIDI_SUSTAIN_EN
        if (ch_ok && (status_q[7:4] == CC)) msg_keep = 1'b1;
`endif
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            state_q     <= StIdle;
            status_q    <= '0;
            data1_q     <= '0;
            msg_valid_q <= 1'b0;
            msg_type_q  <= '0;
            msg_d1_q    <= '0;
            msg_d2_q    <= '0;
            parse_err_q <= 1'b0;
        end else begin
            msg_valid_q <= 1'b0;
            parse_err_q <= 1'b0;
            if (midi.iMidiRe) begin
                if (byte_in >= 8'hF8) begin
                    // realtime: transparent to the parser
                end else if (byte_in >= 8'hF0) begin
                    status_q <= '0;
                    state_q  <= StSkip;
                end else if (byte_in[7]) begin
                    status_q <= byte_in;
                    state_q  <= StWaitD1;
                end else begin
                    unique case (state_q)
                        StIdle: parse_err_q <= 1'b1;
                        StSkip: ;
                        StWaitD1: begin
                            if (one_byte) begin
                                msg_valid_q <= msg_keep;
                                msg_type_q  <= status_q[7:4];
                                msg_d1_q    <= byte_in[6:0];
                                msg_d2_q    <= '0;
                            end else begin
                                data1_q <= byte_in[6:0];
                                state_q <= StWaitD2;
                            end
                        end
                        StWaitD2: begin
                            msg_valid_q <= msg_keep;
                            msg_type_q  <= status_q[7:4];
                            msg_d1_q    <= data1_q;
                            msg_d2_q    <= byte_in[6:0];
                            state_q     <= StWaitD1;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- voice allocation ----------------
    logic [pChannel-1:0]      play_q, play_d, note_on_q, note_on_d;
    logic [pChannel-1:0][6:0] note_q, note_d, vel_q, vel_d;
    logic [pChannel-1:0][7:0] age_q, age_d;
    logic                     steal_q, steal_d;
`ifdef MIDI_SUSTAIN_EN
    logic [pChannel-1:0]      sus_q, sus_d;
    logic                     pedal_q, pedal_d;
`endif

    logic            hit, free, is_on, is_off;
    logic [IdxW-1:0] hit_idx, free_idx, old_idx, sel;

    assign is_on  = (msg_type_q == NOTE_ON) && (msg_d2_q != '0);
    assign is_off = (msg_type_q == NOTE_OFF) || ((msg_type_q == NOTE_ON) && (msg_d2_q == '0));

    // Candidate voices; downward scans leave the lowest matching index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int v = int'(pChannel) - 1; v >= 0; v--) begin
            if (play_q[v] && (note_q[v] == msg_d1_q)) begin
                hit     = 1'b1;
                hit_idx = IdxW'(v);
            end
            if (!play_q[v]) begin
                free     = 1'b1;
                free_idx = IdxW'(v);
            end
        end
        old_idx = '0;
        for (int v = 1; v < int'(pChannel); v++) begin
            if (age_q[v] > age_q[old_idx]) old_idx = IdxW'(v);
        end
    end

    assign sel = hit ? hit_idx : (free ? free_idx : old_idx);

    always_comb begin
        play_d    = play_q;
        note_d    = note_q;
        vel_d     = vel_q;
        age_d     = age_q;
        note_on_d = '0;
        steal_d   = 1'b0;
`ifdef MIDI_SUSTAIN_EN
        sus_d     = sus_q;
        pedal_d   = pedal_q;
`endif
        if (msg_valid_q) begin
            if (is_on) begin
                for (int v = 0; v < int'(pChannel); v++) begin
                    if (play_q[v] && (IdxW'(v) != sel) && (age_q[v] != 8'(AGE_MAX))) begin
                        age_d[v] = age_q[v] + 8'd1;
                    end
                end
                age_d[sel]     = '0;
                play_d[sel]    = 1'b1;
                note_d[sel]    = msg_d1_q;
                vel_d[sel]     = msg_d2_q;
                note_on_d[sel] = 1'b1;
                steal_d        = !hit && !free;
`ifdef MIDI_SUSTAIN_EN
                sus_d[sel]     = 1'b0;
`endif
            end else if (is_off) begin
                for (int v = 0; v < int'(pChannel); v++) begin
                    if (play_q[v] && (note_q[v] == msg_d1_q)) begin
`ifdef MIDI_SUSTAIN_EN
                        if (pedal_q) sus_d[v] = 1'b1;
                        else         play_d[v] = 1'b0;
`else
                        play_d[v] = 1'b0;
`endif
                    end
                end
            end
`ifdef MIDI_SUSTAIN_EN
            else if ((msg_type_q == CC) && (msg_d1_q == CC_SUSTAIN)) begin
                pedal_d = msg_d2_q[6];
                // Pedal release silences everything held only by the pedal.
                if (pedal_q && !msg_d2_q[6]) begin
                    play_d = play_q & ~sus_q;
                    sus_d  = '0;
                end
            end
`endif
        end
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            play_q    <= '0;
            note_q    <= '0;
            vel_q     <= '0;
            age_q     <= '0;
            note_on_q <= '0;
            steal_q   <= 1'b0;
`ifdef MIDI_SUSTAIN_EN
            sus_q     <= '0;
            pedal_q   <= 1'b0;
`endif
        end else begin
            play_q    <= play_d;
            note_q    <= note_d;
            vel_q     <= vel_d;
            age_q     <= age_d;
            note_on_q <= note_on_d;
            steal_q   <= steal_d;
`ifdef MIDI_SUSTAIN_EN
            sus_q     <= sus_d;
            pedal_q   <= pedal_d;
`endif
        end
    end

    // ROM is addressed with next-state notes so frequency lands with the note.
    logic [pChannel-1:0][pAudioBitDepth-1:0] freq;

    midi_note_freq_rom #(
        .pChannel      (pChannel),
        .pAudioBitDepth(pAudioBitDepth),
        .pSampleRate   (pSampleRate)
    ) u_rom (
        .iCLK   (iCLK),
        .inRST  (inRST),
        .rd_en  (note_on_d),
        .rd_addr(note_d),
        .rd_data(freq)
    );

    assign oAudioFreq  = freq;
    assign oAudioPlay  = play_q;
    assign oNoteNumber = note_q;
    assign oVelocity   = vel_q;
    assign oNoteOn     = note_on_q;
    assign oVoiceSteal = steal_q;
    assign oParseErr   = parse_err_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: two instances (2 voices omni, 4 voices channel 2)
// share one byte stream and are compared every cycle against a reference model.
module tb_midi_voice_allocator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    midi_voice_allocator_if bus ();

    logic [31:0] freq_a;
    logic [1:0]  play_a, on_a;
    logic [13:0] note_a, vel_a;
    logic        steal_a, perr_a;
    logic [63:0] freq_b;
    logic [3:0]  play_b, on_b;
    logic [27:0] note_b, vel_b;
    logic        steal_b, perr_b;

    midi_voice_allocator #(
        .pChannel(2), .pAudioBitDepth(16), .pSampleRate(48000), .pMidiCh(16)
    ) dut_a (
        .iCLK(clk), .inRST(rst_n), .midi(bus.slave),
        .oAudioFreq(freq_a), .oAudioPlay(play_a), .oNoteNumber(note_a), .oVelocity(vel_a),
        .oNoteOn(on_a), .oVoiceSteal(steal_a), .oParseErr(perr_a)
    );

    midi_voice_allocator #(
        .pChannel(4), .pAudioBitDepth(16), .pSampleRate(48000), .pMidiCh(2)
    ) dut_b (
        .iCLK(clk), .inRST(rst_n), .midi(bus.slave),
        .oAudioFreq(freq_b), .oAudioPlay(play_b), .oNoteNumber(note_b), .oVelocity(vel_b),
        .oNoteOn(on_b), .oVoiceSteal(steal_b), .oParseErr(perr_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    int nv[2]  = '{2, 4};
    int chn[2] = '{16, 2};
    int play[2][4], note[2][4], vel[2][4], age[2][4], sus[2][4], fq[2][4], on_p[2][4];
    int steal_p[2], pedal[2];
    int rs, skip, perr_e;
    int dq[$];
    int pend_v, pend_s, pend_d1, pend_d2;

    function automatic int ref_inc(int n);
        real x;
        int  r;
        x = 440.0 * $pow(2.0, (real'(n) - 69.0) / 12.0) * 65536.0 / 48000.0;
        r = $rtoi($floor(x + 0.5));
        if (r > 65535) r = 65535;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                play[k][i] = 0; note[k][i] = 0; vel[k][i] = 0; age[k][i] = 0;
                sus[k][i] = 0; fq[k][i] = 0; on_p[k][i] = 0;
            end
            steal_p[k] = 0;
            pedal[k] = 0;
        end
        rs = 0; skip = 0; perr_e = 0; pend_v = 0;
        dq.delete();
    endtask

    task automatic apply(int k);
        int t, idx;
        t = pend_s >> 4;
        if (chn[k] != 16 && (pend_s & 15) != chn[k]) return;
        if (t == 9 && pend_d2 > 0) begin
            idx = -1;
            for (int i = 0; i < nv[k]; i++)
                if (idx < 0 && play[k][i] != 0 && note[k][i] == pend_d1) idx = i;
            for (int i = 0; i < nv[k]; i++)
                if (idx < 0 && play[k][i] == 0) idx = i;
            if (idx < 0) begin
                steal_p[k] = 1;
                idx = 0;
                for (int i = 1; i < nv[k]; i++) if (age[k][i] > age[k][idx]) idx = i;
            end
            for (int i = 0; i < nv[k]; i++)
                if (i != idx && play[k][i] != 0) age[k][i] = (age[k][i] < 255) ? age[k][i] + 1 : 255;
            age[k][idx] = 0; play[k][idx] = 1; note[k][idx] = pend_d1; vel[k][idx] = pend_d2;
            sus[k][idx] = 0; on_p[k][idx] = 1; fq[k][idx] = ref_inc(pend_d1);
        end else if (t == 8 || t == 9) begin
            for (int i = 0; i < nv[k]; i++) begin
                if (play[k][i] != 0 && note[k][i] == pend_d1) begin
`ifdef MIDI_SUSTAIN_EN
                    if (pedal[k] != 0) sus[k][i] = 1;
                    else play[k][i] = 0;
`else
                    play[k][i] = 0;
`endif
                end
            end
        end
`ifdef MIDI_SUSTAIN_EN
        else if (t == 11 && pend_d1 == 64) begin
            if (pedal[k] != 0 && pend_d2 < 64) begin
                for (int i = 0; i < nv[k]; i++) begin
                    if (sus[k][i] != 0) play[k][i] = 0;
                    sus[k][i] = 0;
                end
            end
            pedal[k] = (pend_d2 >= 64) ? 1 : 0;
        end
`endif
    endtask

    // One clock edge: finish last cycle's message, then parse this cycle's byte.
    task automatic model_edge(bit re, int b);
        int need;
        for (int k = 0; k < 2; k++) begin
            steal_p[k] = 0;
            for (int i = 0; i < 4; i++) on_p[k][i] = 0;
        end
        perr_e = 0;
        if (pend_v != 0) begin
            apply(0);
            apply(1);
        end
        pend_v = 0;
        if (re) begin
            if (b >= 'hF8) begin
                need = 0;
            end else if (b >= 'hF0) begin
                rs = 0; skip = 1; dq.delete();
            end else if (b >= 'h80) begin
                rs = b; skip = 0; dq.delete();
            end else if (rs == 0) begin
                if (skip == 0) perr_e = 1;
            end else begin
                dq.push_back(b);
                need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
                if (dq.size() == need) begin
                    pend_v = 1; pend_s = rs; pend_d1 = dq[0];
                    pend_d2 = (need == 2) ? dq[1] : 0;
                    dq.delete();
                end
            end
        end
    endtask

    function automatic logic [63:0] exp_vec(int k, int sel);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nv[k]; i++) begin
            case (sel)
                0: r[i] = (play[k][i] != 0);
                1: r[i*7 +: 7] = 7'(note[k][i]);
                2: r[i*7 +: 7] = 7'(vel[k][i]);
                3: r[i*16 +: 16] = 16'(fq[k][i]);
                default: r[i] = (on_p[k][i] != 0);
            endcase
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("a.play",  64'(play_a),  exp_vec(0, 0));
        chk("a.note",  64'(note_a),  exp_vec(0, 1));
        chk("a.vel",   64'(vel_a),   exp_vec(0, 2));
        chk("a.freq",  64'(freq_a),  exp_vec(0, 3));
        chk("a.on",    64'(on_a),    exp_vec(0, 4));
        chk("a.steal", 64'(steal_a), 64'(steal_p[0]));
        chk("a.perr",  64'(perr_a),  64'(perr_e));
        chk("b.play",  64'(play_b),  exp_vec(1, 0));
        chk("b.note",  64'(note_b),  exp_vec(1, 1));
        chk("b.vel",   64'(vel_b),   exp_vec(1, 2));
        chk("b.freq",  freq_b,       exp_vec(1, 3));
        chk("b.on",    64'(on_b),    exp_vec(1, 4));
        chk("b.steal", 64'(steal_b), 64'(steal_p[1]));
        chk("b.perr",  64'(perr_b),  64'(perr_e));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(bit re, logic [7:0] b);
        bus.iMidiRe = re;
        bus.iMidiRd = b;
        @(posedge clk);
        model_edge(re, int'(b));
        #1;
        check_all();
    endtask

    task automatic send(logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle();
        tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        bus.iMidiRe = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [3:0] ty;
        logic [3:0] ch;
        int r;
        r = $urandom_range(0, 99);
        case ($urandom_range(0, 3))
            0: ch = 4'd0;
            1: ch = 4'd5;
            default: ch = 4'd2;
        endcase
        case ($urandom_range(0, 8))
            0: ty = 4'h8;
            1, 2, 3: ty = 4'h9;
            4: ty = 4'hB;
            5: ty = 4'hC;
            6: ty = 4'hD;
            7: ty = 4'hE;
            default: ty = 4'hA;
        endcase
        if (r < 6) return 8'hF8 + 8'($urandom_range(0, 7));
        if (r < 9) return 8'hF0 + 8'($urandom_range(0, 7));
        if (r < 35) return {ty, ch};
        if (r < 45) return 8'h00;
        if (r < 85) return 8'($urandom_range(8'h3C, 8'h41));
        return 8'($urandom_range(0, 127));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bus.iMidiRe = 1'b0;
        bus.iMidiRd = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Basic note on: A4 on voice 0.
        send(8'h90); send(8'h45); send(8'h40); idle();
        chk("t1.freq0", 64'(freq_a[15:0]), 64'd601);
        chk("t1.noteon", 64'(on_a), 64'd1);

        // Oldest voice stolen when both voices sound.
        do_reset();
        send(8'h90); send(8'h36); send(8'h30); idle();
        send(8'h90); send(8'h40); send(8'h20); idle();
        send(8'h90); send(8'h44); send(8'h20); idle();
        chk("t2.steal", 64'(steal_a), 64'd1);
        chk("t2.note0", 64'(note_a[6:0]), 64'h44);
        chk("t2.note1", 64'(note_a[13:7]), 64'h40);

        // Running status, back-to-back bytes, velocity-0 note off.
        do_reset();
        send(8'h90); send(8'h3C); send(8'h50); send(8'h3E); send(8'h50);
        send(8'h3C); send(8'h00); idle();
        chk("t3.play", 64'(play_a), 64'b10);

        // Realtime interleaving, SKIP, orphan data.
        do_reset();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h50); idle();
        chk("t4.note0", 64'(note_a[6:0]), 64'h3C);
        send(8'hF0); send(8'h3C); idle();
        chk("t4.skip", 64'(perr_a), 64'd0);
        do_reset();
        send(8'h3C);
        chk("t4.perr", 64'(perr_a), 64'd1);

        // Channel filter and mid-message reset.
        do_reset();
        send(8'h91); send(8'h3C); send(8'h50); idle();
        chk("t5.ch1", 64'(play_b), 64'd0);
        send(8'h92); send(8'h3C); send(8'h50); idle();
        chk("t5.ch2", 64'(play_b), 64'b0001);
        send(8'h92); send(8'h3C);
        bus.iMidiRe = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("t5.rstplay", 64'(play_b), 64'd0);
        chk("t5.rstfreq", freq_b, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h50);
        chk("t5.perr", 64'(perr_b), 64'd1);

        // Sustain pedal (or plain note off without the feature).
        do_reset();
        send(8'h90); send(8'h3C); send(8'h50); idle();
        send(8'hB0); send(8'h40); send(8'h7F); idle();
        send(8'h80); send(8'h3C); send(8'h00); idle();
`ifdef MIDI_SUSTAIN_EN
        chk("t6.held", 64'(play_a[0]), 64'd1);
`else
        chk("t6.off", 64'(play_a[0]), 64'd0);
`endif
        send(8'hB0); send(8'h40); send(8'h00); idle();
        chk("t6.release", 64'(play_a[0]), 64'd0);

        // Random byte stream against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(rand_byte());
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Parametrised successor to the single-voice MIDI audio decoder.
- Parses a raw MIDI byte stream with running status, realtime and system-message handling, and filters by MIDI channel.
- Allocates Note On/Off events across pChannel polyphonic voices, using retrigger, lowest-free and oldest-steal rules.
- Outputs per-voice phase-increment, play, note and velocity to the audio oscillator bank.

Parameters:
pChannel, 4, number of voices (1..16)
pAudioBitDepth, 16, phase-increment width per voice
pSampleRate, 48000, audio sample rate in Hz used for the increment table
pMidiCh, 16, MIDI channel accepted (0..15); 16 = omni

Ports:
iCLK  in  1  system clock
inRST  in  1  asynchronous active-low reset
iMidiRd  in  8  MIDI byte
iMidiRe  in  1  byte strobe; one byte per high cycle; may be high every cycle
oAudioFreq  out  pChannel*pAudioBitDepth  per-voice phase increment; voice v at [v*W +: W]
oAudioPlay  out  pChannel  voice sounding
oNoteNumber  out  pChannel*7  per-voice note number
oVelocity  out  pChannel*7  per-voice velocity
oNoteOn  out  pChannel  1-cycle pulse when a voice is (re)allocated
oVoiceSteal  out  1  1-cycle pulse when allocation stole a sounding voice
oParseErr  out  1  1-cycle pulse on an orphan data byte

Behaviour:
- Reset: inRST low clears all outputs, running status, parser state and voice ages to 0, asynchronously; this applies mid-message too, and a partial message is lost.
- Parser states:
  - IDLE: no running status.
  - WAIT_D1: status byte held.
  - WAIT_D2: first data byte held.
  - SKIP: system exclusive or common.
- Bytes 0xF8-0xFF are realtime: ignored with no state change.
- Bytes 0xF0-0xF7 clear running status and go to SKIP. SKIP discards data bytes until the next status byte.
- Status bytes 0x80-0xEF store running status and go to WAIT_D1.
  - 0xCn and 0xDn are 1-data-byte messages; all others take 2 data bytes.
- A complete message returns the parser to WAIT_D1 with running status kept.
- A data byte received in IDLE is discarded and pulses oParseErr.
- Messages whose channel does not equal pMidiCh are parsed and then discarded; omni accepts all channels. 0xA/0xB/0xC/0xD/0xE messages are discarded.
- Execution fires on the cycle after the final data byte strobe (cycle E).
- Note On with velocity > 0, selection priority:
  1. A voice that has oAudioPlay=1 and the same note is retriggered; no steal.
  2. Otherwise the lowest-index voice with oAudioPlay=0 is taken.
  3. Otherwise the voice with the highest age is stolen (lowest index on tie), and oVoiceSteal pulses.
- On allocation:
  - The selected voice gets age 0.
  - All other playing voices increment age, saturating at 255.
- Note Off, or Note On with velocity 0: every playing voice with a matching note clears oAudioPlay. An unmatched note has no effect.
- Latency, all on cycle E+1:
  - oNoteNumber, oVelocity and oAudioPlay update.
  - oAudioFreq updates from the registered table read, so all voice outputs change together.
  - oNoteOn and oVoiceSteal pulse.
- Throughput: one message per 2 byte cycles with running status; there are no stalls and no backpressure.
- Table value: increment = round(440*2^((n-69)/12) * 2^W / pSampleRate), saturating at 2^W-1.

Optional Feature:
- Macro MIDI_SUSTAIN_EN.
- Defined: Control Change Bn 40 vv (after the channel filter) is decoded as the sustain pedal.
  - While vv >= 64, Note Off sets a per-voice sustained flag instead of clearing play.
  - The transition to vv < 64 clears play on all sustained voices on cycle E+1.
  - A retrigger or steal clears the sustained flag of that voice.
- Undefined: Bn messages are discarded like other unsupported messages, and there is no sustain state.

Decomposition:
- midi_pkg:
  - status-nibble constants (NOTE_OFF=8, NOTE_ON=9, CC=B, PROG=C, CHPRESS=D).
  - CC_SUSTAIN=0x40.
  - parser state enum.
  - AGE_MAX=255.
  - Elaboration function note_to_inc(n, W, fs).
- Sub-module midi_note_freq_rom: 128 x pAudioBitDepth registered ROM with one read port per voice, initialised via note_to_inc.

Test Plan:
1. pChannel=2, W=16, fs=48000; bytes 90 45 40 → cycle E+1: voice0 play=1, note=0x45, vel=0x40, freq=601, oNoteOn=01.
2. pChannel=2; 90 36 30, 90 40 20, 90 44 20 → third note steals voice0 (0x36 is oldest): voice0 note=0x44, oVoiceSteal pulse, voice1 unchanged (0x40).
3. Running status 90 3C 50 3E 50 3C 00 → voice0 0x3C on, voice1 0x3E on, then voice0 play=0 via velocity 0; voice1 still playing.
4. 90 F8 3C FE 50 (realtime interleaved) → identical to 90 3C 50; then 3C with no running status after F0 → discarded, no oParseErr (SKIP); after reset, 3C → oParseErr pulse.
5. pMidiCh=2: 91 3C 50 ignored, 92 3C 50 allocates voice0; inRST low mid-message (after 92 3C) → all outputs 0 immediately, next 50 → oParseErr.
6. MIDI_SUSTAIN_EN: 90 3C 50, B0 40 7F, 80 3C 00 → play stays 1; B0 40 00 → play=0 on E+1; without the macro, play=0 right after 80 3C 00.
